// File: rtl/button_events_pkg.sv
// Shared definitions for the button event generator: state encoding,
// counter width and the terminal-count helper used by the FSM.
package button_events_pkg;

  // Width of the hold/repeat cycle counter.
  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // Encoding is fixed so other blocks and debug views can decode it.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // True when a counter that started at 0 has completed `period` cycles.
  function automatic logic at_term(input cnt_t c, input cnt_t period);
    return c == (period - cnt_t'(1));
  endfunction

endpackage : button_events_pkg

// File: rtl/button_events_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous button level into the
// clk domain. q is the output of the second flop.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift d through two flops; both clear immediately on reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/button_events.sv
// Button event generator: turns a debounced button level into press,
// release, long-press and auto-repeat pulses plus a held level.
//
// Build option: define BUTTON_EVENTS_REPEAT_EN to enable the auto-repeat
// pulse while held. Without it repeat_pulse is constant 0, REPEAT_PERIOD
// is only range-checked, and the counter holds once HELD is reached.
//
// The release and repeat events are exposed as release_pulse and
// repeat_pulse because `release` and `repeat` are SystemVerilog keywords.
module button_events
  import button_events_pkg::*;
#(
  parameter int unsigned LONG_DELAY    = 125000,
  parameter int unsigned REPEAT_PERIOD = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Reject parameter values the counter logic cannot honour.
  if (LONG_DELAY < 2) begin : g_bad_long_delay
    $error("button_events: LONG_DELAY must be at least 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_repeat_period
    $error("button_events: REPEAT_PERIOD must be at least 2");
  end

  localparam cnt_t LONG_CNT = cnt_t'(LONG_DELAY);
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam cnt_t REPEAT_CNT = cnt_t'(REPEAT_PERIOD);
`endif

  logic   in_s;
  state_t state;
  cnt_t   cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in),
    .q     (in_s)
  );

  // Event FSM with registered outputs. Release is tested first in every
  // pressed state so it wins over a coinciding terminal count, which also
  // keeps the four pulses mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      // Pulses default low and are raised for exactly one cycle below.
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_s) begin
            state <= ST_PRESSED;
            cnt   <= '0;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (!in_s) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end else if (at_term(cnt, LONG_CNT)) begin
            state      <= ST_HELD;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end

        ST_HELD: begin
          if (!in_s) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            release_pulse <= 1'b1;
            held          <= 1'b0;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (at_term(cnt, REPEAT_CNT)) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
`endif
        end

        // NOTE: an explicit default recovers from the unused encoding and
        // keeps the case fully specified.
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

  // At most one event pulse may be active in any cycle.
  assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({press, release_pulse, long_press, repeat_pulse}))
    else $error("button_events: more than one event pulse active");

endmodule : button_events

// File: tb/tb_button_events.sv
// Self-checking bench for button_events (LONG_DELAY=8, REPEAT_PERIOD=4).
// The reference model tracks how many consecutive cycles the synchronized
// button has been seen pressed and derives every event from that run length.
module tb_button_events;

  localparam int LD = 8;
  localparam int RP = 4;
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in = 1'b0;
  logic press, release_pulse, long_press, repeat_pulse, held;

  button_events #(
    .LONG_DELAY    (LD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in            (in),
    .press         (press),
    .release_pulse (release_pulse),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: two-stage delay line plus length of the current press run.
  bit m_d1, m_d2;
  int m_run;
  bit m_press, m_rel, m_long, m_rep, m_held;

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_run = 0;
    m_press = 0; m_rel = 0; m_long = 0; m_rep = 0; m_held = 0;
  endtask

  // One rising edge: the FSM sees the value the second flop held before it.
  task automatic model_edge(input bit in_now);
    bit sampled;
    sampled = m_d2;
    m_d2 = m_d1;
    m_d1 = in_now;
    m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
    if (sampled) begin
      m_run++;
      m_press = (m_run == 1);
      m_long  = (m_run == 1 + LD);
      m_rep   = REP_EN && (m_run > 1 + LD) && ((m_run - 1 - LD) % RP == 0);
    end else begin
      m_rel = (m_run > 0);
      m_run = 0;
    end
    m_held = (m_run > 0);
  endtask

  // Observed-event statistics for directed scenarios.
  int cyc = 0;
  int n_press, n_rel, n_long, n_rep, n_held;
  int t_press, t_rel, t_long;

  task automatic clear_stats();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_held = 0;
    t_press = -1; t_rel = -1; t_long = -1;
  endtask

  // Advance one clock, update the model, then compare outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_edge(in);
    #1;
    check("outputs", {27'd0, press, release_pulse, long_press, repeat_pulse, held},
          {27'd0, m_press, m_rel, m_long, m_rep, m_held});
    check("onehot", 32'($countones({press, release_pulse, long_press, repeat_pulse}) <= 1), 32'd1);
    if (press)         begin n_press++; t_press = cyc; end
    if (release_pulse) begin n_rel++;   t_rel   = cyc; end
    if (long_press)    begin n_long++;  t_long  = cyc; end
    if (repeat_pulse)  n_rep++;
    if (held)          n_held++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int c0;

  initial begin
    model_reset();
    clear_stats();

    // Reset state.
    #2;
    check("reset_outputs", {27'd0, press, release_pulse, long_press, repeat_pulse, held}, 32'd0);
    run(3);
    #3 rst_n = 1'b1;
    run(3);

    // Short press: 5 cycles high.
    clear_stats();
    c0 = cyc; in = 1'b1;
    run(5);
    in = 1'b0;
    run(10);
    check("short_press_lat", 32'(t_press - c0), 32'd3);
    check("short_rel_gap", 32'(t_rel - t_press), 32'd5);
    check("short_no_long", 32'(n_long), 32'd0);
    check("short_no_rep", 32'(n_rep), 32'd0);
    check("short_held_len", 32'(n_held), 32'd5);

    // Long hold: 30 cycles high.
    clear_stats();
    c0 = cyc; in = 1'b1;
    run(30);
    in = 1'b0;
    run(10);
    check("long_press_cnt", 32'(n_press), 32'd1);
    check("long_delay", 32'(t_long - t_press), 32'(LD));
    check("long_rep_cnt", 32'(n_rep), REP_EN ? 32'd5 : 32'd0);
    check("long_rel_cnt", 32'(n_rel), 32'd1);
    check("long_held_len", 32'(n_held), 32'd30);

    // Release coinciding with the long-press terminal count.
    clear_stats();
    in = 1'b1;
    run(LD);
    in = 1'b0;
    run(10);
    check("coinc_no_long", 32'(n_long), 32'd0);
    check("coinc_rel_cnt", 32'(n_rel), 32'd1);
    check("coinc_rel_gap", 32'(t_rel - t_press), 32'(LD));

    // Reset while HELD, with the button still pressed.
    clear_stats();
    in = 1'b1;
    run(15);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_clear", {27'd0, press, release_pulse, long_press, repeat_pulse, held}, 32'd0);
    model_reset();
    run(2);
    #3 rst_n = 1'b1;
    c0 = cyc;
    clear_stats();
    run(6);
    check("rst_no_release", 32'(n_rel), 32'd0);
    check("rst_repress_lat", 32'(t_press - c0), 32'd3);
    in = 1'b0;
    run(6);

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      run($urandom_range(1, 2 * LD + 3 * RP));
    end
    in = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_button_events

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter LONG_DELAY, default 125000: cycles held in PRESSED before a long-press event; legal range 2..2^32-1.
REQ-002 SHALL have parameter REPEAT_PERIOD, default 25000: cycles between repeat events while HELD; legal range 2..2^32-1.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in  input  1  debounced button level, asynchronous to clk, 1 = pressed.
REQ-006 SHALL have port press  output  1  one-cycle pulse on accepted press.
REQ-007 SHALL have port release  output  1  one-cycle pulse on accepted release.
REQ-008 SHALL have port long_press  output  1  one-cycle pulse when the hold reaches LONG_DELAY.
REQ-009 SHALL have port repeat  output  1  one-cycle pulse every REPEAT_PERIOD cycles while HELD.
REQ-010 SHALL have port held  output  1  level, high while state is PRESSED or HELD.

Function
REQ-011 SHALL pass in through a two-flop synchronizer; in_s is the second flop's output.
REQ-012 SHALL implement states IDLE, PRESSED, HELD, with a 32-bit cycle counter cnt.
REQ-013 IDLE and in_s=1: go to PRESSED, cnt<=0, press=1 in the next cycle (press first high at the 3rd rising edge after in rises).
REQ-014 PRESSED and in_s=1: cnt increments; when cnt==LONG_DELAY-1, go to HELD, cnt<=0, long_press=1 for one cycle.
REQ-015 HELD and in_s=1: cnt increments; when cnt==REPEAT_PERIOD-1, cnt<=0, repeat=1 for one cycle; state remains HELD.
REQ-016 PRESSED or HELD and in_s=0: go to IDLE, cnt<=0, release=1 for one cycle.
REQ-017 Release SHALL take priority when it coincides with a cnt terminal value; no long_press or repeat then.
REQ-018 At most one of press, release, long_press, repeat SHALL be high in any cycle.
REQ-019 held SHALL be a registered output, rising in the same cycle as press and falling in the same cycle as release.
REQ-020 cnt SHALL never wrap; it is cleared on every state change and at each terminal value.
REQ-021 A press shorter than LONG_DELAY cycles SHALL produce only press and release.

Reset
REQ-022 rst_n=0 SHALL immediately clear both synchronizer flops, cnt, state (IDLE) and all outputs to 0.
REQ-023 Reset during PRESSED or HELD SHALL emit no release pulse.
REQ-024 If in is high when rst_n deasserts, press SHALL be generated as for a fresh press.

Configuration
REQ-025 Macro BUTTON_EVENTS_REPEAT_EN defined: repeat behaves per REQ-015.
REQ-026 Macro undefined: repeat tied to 0, REPEAT_PERIOD ignored, cnt holds in HELD; all other behaviour unchanged.

Structure
REQ-027 The state encoding (IDLE=0, PRESSED=1, HELD=2) and the counter width (32) SHALL live in a shared package.
REQ-028 The synchronizer SHALL be a sub-module named sync_2ff, with ports clk, rst_n, d, q.

Verification (LONG_DELAY=8, REPEAT_PERIOD=4, macro defined unless stated)
REQ-029 Short press: in high for 5 cycles -> press at edge 3, release 5 cycles after press, no long_press or repeat, held high for 5 cycles.
REQ-030 Long hold: in high for 30 cycles -> press, long_press 8 cycles after press, then repeat every 4 cycles (5 pulses), then release.
REQ-031 Coincidence: in_s falls in the cycle cnt==7 in PRESSED -> release only, no long_press.
REQ-032 Reset mid-HELD: rst_n low for 2 cycles -> all outputs 0 asynchronously, no release; in still high -> press 3 edges after rst_n rises.
REQ-033 Macro undefined: in high for 30 cycles -> press and long_press, zero repeat pulses, held stays high until release.
